// File: rtl/pcie_dma_pkg.sv
// Shared types and constants for the PCIe DMA schedulers.
package pcie_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } sched_state_e;

  localparam int unsigned PAGE_BYTES = 4096;

  function automatic int unsigned bytes_per_beat(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/pcie_burst_len_calc.sv
// Burst length limiter (burst cap, frame remainder, 4 KB page, FIFO level)
// and the address/offset step adder used when a burst retires.
module pcie_burst_len_calc
  import pcie_dma_pkg::*;
#(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned LVL_W     = 11,
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic [ADDR_W-1:0]           addr,
  input  logic [ADDR_W-1:0]           frame_off,
  input  logic [ADDR_W-1:0]           frame_bytes,
  input  logic [LVL_W-1:0]            level,
  input  logic [$clog2(BURST_LEN):0]  step_len,
  output logic [$clog2(BURST_LEN):0]  len_full,
  output logic [$clog2(BURST_LEN):0]  len,
  output logic [ADDR_W-1:0]           addr_nxt,
  output logic [ADDR_W-1:0]           off_nxt
);

  localparam int unsigned LEN_W = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0] BPB   = ADDR_W'(bytes_per_beat(DATA_W));
  localparam logic [ADDR_W-1:0] PAGE  = ADDR_W'(PAGE_BYTES);
  localparam logic [ADDR_W-1:0] BURST = ADDR_W'(BURST_LEN);

  logic [ADDR_W-1:0] rem_frame;
  logic [ADDR_W-1:0] to_4k;
  logic [ADDR_W-1:0] lvl_ext;
  logic [ADDR_W-1:0] cap;
  logic [ADDR_W-1:0] cap_lvl;
  logic [ADDR_W-1:0] step_bytes;

  // cap never exceeds BURST_LEN, so the truncation to LEN_W is lossless
  always_comb begin
    rem_frame  = (frame_bytes - frame_off) / BPB;
    to_4k      = (PAGE - {{(ADDR_W-12){1'b0}}, addr[11:0]}) / BPB;
    lvl_ext    = ADDR_W'(level);
    cap        = BURST;
    if (rem_frame < cap) cap = rem_frame;
    if (to_4k < cap)     cap = to_4k;
    cap_lvl    = (lvl_ext < cap) ? lvl_ext : cap;
    len_full   = LEN_W'(cap);
    len        = LEN_W'(cap_lvl);
    step_bytes = ADDR_W'(step_len) * BPB;
    addr_nxt   = addr + step_bytes;
    off_nxt    = frame_off + step_bytes;
  end

endmodule

// File: rtl/pcie_fifo_burst_sched.sv
// Read-side scheduler: turns FIFO water level into 4 KB-safe DMA write bursts
// wrapping inside a host frame buffer.
//
//   state | meaning
//   IDLE  | waiting for enough data (or a flush) to start a burst
//   REQ   | dma_req held with latched addr/len until dma_ack
//   READ  | fifo_rd_en for exactly dma_len non-empty cycles
//   DRAIN | last beats leave the read-latency pipe, then pointers advance
module pcie_fifo_burst_sched
  import pcie_dma_pkg::*;
#(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned LVL_W     = 11,
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [ADDR_W-1:0]           cfg_base,
  input  logic [ADDR_W-1:0]           cfg_frame_bytes,
  input  logic                        frame_end,
  output logic                        fifo_rd_en,
  input  logic [DATA_W-1:0]           fifo_rd_data,
  input  logic                        fifo_rd_empty,
  input  logic [LVL_W-1:0]            fifo_rd_level,
  output logic                        dma_req,
  input  logic                        dma_ack,
  output logic [ADDR_W-1:0]           dma_addr,
  output logic [$clog2(BURST_LEN):0]  dma_len,
  output logic                        dma_valid,
  output logic [DATA_W-1:0]           dma_data,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int unsigned LEN_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [ADDR_W-1:0] frame_q, frame_d;
  logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
  logic [LEN_W-1:0]  dma_len_q, dma_len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;
  logic              init_q, init_d;
  logic              flush_q, flush_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] eff_addr, eff_off, eff_frame;
  logic [ADDR_W-1:0] addr_nxt, off_nxt;
  logic [LEN_W-1:0]  len_full, len;
  logic              rd_en;
  logic              start;

  // Before the first enable the pointer still holds reset values, so the
  // limiter looks at the configuration directly for that first decision.
  always_comb begin
    eff_addr  = init_q ? addr_q  : cfg_base;
    eff_off   = init_q ? off_q   : '0;
    eff_frame = init_q ? frame_q : cfg_frame_bytes;
  end

  pcie_burst_len_calc #(
    .DATA_W    (DATA_W),
    .LVL_W     (LVL_W),
    .BURST_LEN (BURST_LEN),
    .ADDR_W    (ADDR_W)
  ) u_len_calc (
    .addr        (eff_addr),
    .frame_off   (eff_off),
    .frame_bytes (eff_frame),
    .level       (fifo_rd_level),
    .step_len    (dma_len_q),
    .len_full    (len_full),
    .len         (len),
    .addr_nxt    (addr_nxt),
    .off_nxt     (off_nxt)
  );

  // len == len_full means the level covers the full allowed burst
  assign rd_en = (state_q == READ) && !fifo_rd_empty;
  assign start = (state_q == IDLE) && enable && (len != '0) &&
                 ((len == len_full) || flush_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    frame_d    = frame_q;
    dma_addr_d = dma_addr_q;
    dma_len_d  = dma_len_q;
    beat_cnt_d = beat_cnt_q;
    drn_cnt_d  = drn_cnt_q;
    init_d     = init_q;
    done_d     = 1'b0;
    vld_sr_d   = RD_LAT'({vld_sr_q, rd_en});

    flush_d = flush_q;
    if ((state_q == IDLE) && (fifo_rd_level == '0)) flush_d = 1'b0;
    if (frame_end) flush_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (enable && !init_q) begin
          addr_d  = cfg_base;
          off_d   = '0;
          frame_d = cfg_frame_bytes;
          init_d  = 1'b1;
        end
        if (start) begin
          dma_addr_d = eff_addr;
          dma_len_d  = len;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (dma_ack) begin
          beat_cnt_d = dma_len_q;
          state_d    = READ;
        end
      end
      READ: begin
        if (rd_en) begin
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (beat_cnt_q == LEN_W'(1)) begin
            drn_cnt_d = DRN_W'(RD_LAT - 1);
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drn_cnt_q == '0) begin
          addr_d = addr_nxt;
          off_d  = off_nxt;
          if (off_nxt == frame_q) begin
            addr_d  = cfg_base;
            off_d   = '0;
            frame_d = cfg_frame_bytes;
            done_d  = 1'b1;
          end
          state_d = IDLE;
        end else begin
          drn_cnt_d = drn_cnt_q - DRN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      frame_q    <= '0;
      dma_addr_q <= '0;
      dma_len_q  <= '0;
      beat_cnt_q <= '0;
      vld_sr_q   <= '0;
      drn_cnt_q  <= '0;
      init_q     <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      frame_q    <= frame_d;
      dma_addr_q <= dma_addr_d;
      dma_len_q  <= dma_len_d;
      beat_cnt_q <= beat_cnt_d;
      vld_sr_q   <= vld_sr_d;
      drn_cnt_q  <= drn_cnt_d;
      init_q     <= init_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign dma_req    = (state_q == REQ);
  assign dma_addr   = dma_addr_q;
  assign dma_len    = dma_len_q;
  assign dma_valid  = vld_sr_q[RD_LAT-1];
  assign dma_data   = dma_valid ? fifo_rd_data : '0;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pcie_fifo_burst_sched.sv
// Directed bench with a behavioural FIFO and burst/beat scoreboards.
module tb_pcie_fifo_burst_sched;

  localparam int DATA_W    = 128;
  localparam int LVL_W     = 11;
  localparam int BURST_LEN = 32;
  localparam int RD_LAT    = 1;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = $clog2(BURST_LEN) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic              frame_end = 1'b0;
  logic              dma_ack = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [ADDR_W-1:0] cfg_frame_bytes = '0;
  logic              fifo_rd_en;
  logic              fifo_rd_empty;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic [LVL_W-1:0]  fifo_rd_level;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_valid;
  logic [DATA_W-1:0] dma_data;
  logic              frame_done;
  logic              busy;

  int push_cnt = 0;
  int pop_cnt  = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_t;

  burst_t            exp_burst[$];
  logic [DATA_W-1:0] exp_beat[$];

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   req_cycles = 0;
  int   ack_wait = 0;
  logic prev_req = 1'b0;
  logic prev_rd_en = 1'b0;
  logic prev_rst = 1'b0;

  pcie_fifo_burst_sched #(
    .DATA_W    (DATA_W),
    .LVL_W     (LVL_W),
    .BURST_LEN (BURST_LEN),
    .RD_LAT    (RD_LAT),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .cfg_base        (cfg_base),
    .cfg_frame_bytes (cfg_frame_bytes),
    .frame_end       (frame_end),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_rd_empty   (fifo_rd_empty),
    .fifo_rd_level   (fifo_rd_level),
    .dma_req         (dma_req),
    .dma_ack         (dma_ack),
    .dma_addr        (dma_addr),
    .dma_len         (dma_len),
    .dma_valid       (dma_valid),
    .dma_data        (dma_data),
    .frame_done      (frame_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] beat(input int n);
    return {4{n ^ 32'h5A00_0000}};
  endfunction

  // FIFO model, one cycle read latency; FIFO contents survive scheduler reset
  assign fifo_rd_level = LVL_W'(push_cnt - pop_cnt);
  assign fifo_rd_empty = (push_cnt == pop_cnt);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= beat(pop_cnt);
      pop_cnt      <= pop_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      exp_beat.push_back(beat(push_cnt));
      push_cnt++;
    end
  endtask

  task automatic expect_burst(input logic [ADDR_W-1:0] a, input int l);
    burst_t b;
    b.addr = a;
    b.len  = LEN_W'(l);
    exp_burst.push_back(b);
  endtask

  task automatic tick();
    burst_t b;
    @(negedge clk);
    if (rst_n) begin
      chk("rd_en_while_empty", DATA_W'(fifo_rd_en & fifo_rd_empty), '0);
      if (prev_rst) chk("valid_latency", DATA_W'(dma_valid), DATA_W'(prev_rd_en));
      if (dma_valid) begin
        chk("beat_expected", DATA_W'(exp_beat.size() > 0), DATA_W'(1));
        if (exp_beat.size() > 0) chk("beat_data", dma_data, exp_beat.pop_front());
      end
      if (dma_req && !prev_req) begin
        chk("burst_expected", DATA_W'(exp_burst.size() > 0), DATA_W'(1));
        if (exp_burst.size() > 0) begin
          b = exp_burst.pop_front();
          chk("burst_addr", DATA_W'(dma_addr), DATA_W'(b.addr));
          chk("burst_len", DATA_W'(dma_len), DATA_W'(b.len));
        end
      end
      if (dma_req) req_cycles++;
      if (frame_done) done_cnt++;
    end
    prev_req   = dma_req;
    prev_rd_en = fifo_rd_en;
    prev_rst   = rst_n;
    if (dma_req && !dma_ack) begin
      ack_wait++;
      dma_ack = (ack_wait >= 2);
    end else begin
      ack_wait = 0;
      dma_ack  = 1'b0;
    end
  endtask

  task automatic wait_bursts(input string tag, input int max);
    int n = 0;
    while (!(exp_burst.size() == 0 && busy === 1'b0) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_in_time"}, DATA_W'(n < max), DATA_W'(1));
    chk({tag, "_beats_left"}, DATA_W'(exp_beat.size()), DATA_W'(push_cnt - pop_cnt));
  endtask

  task automatic idle_window(input string tag, input int n);
    req_cycles = 0;
    repeat (n) tick();
    chk(tag, DATA_W'(req_cycles), '0);
  endtask

  task automatic resync_beats();
    exp_beat.delete();
    for (int i = pop_cnt; i < push_cnt; i++) exp_beat.push_back(beat(i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    resync_beats();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dma_req"}, DATA_W'(dma_req), '0);
    chk({tag, "_rd_en"}, DATA_W'(fifo_rd_en), '0);
    chk({tag, "_dma_valid"}, DATA_W'(dma_valid), '0);
    chk({tag, "_dma_data"}, dma_data, '0);
    chk({tag, "_dma_addr"}, DATA_W'(dma_addr), '0);
    chk({tag, "_dma_len"}, DATA_W'(dma_len), '0);
    chk({tag, "_frame_done"}, DATA_W'(frame_done), '0);
    chk({tag, "_busy"}, DATA_W'(busy), '0);
  endtask

  initial begin
    int n;

    // 1: full bursts from a level of 40
    cfg_base        = 32'h1000_0000;
    cfg_frame_bytes = 32'h0010_0000;
    enable          = 1'b1;
    push_beats(40);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (2) tick();
    expect_burst(32'h1000_0000, 32);
    rst_n = 1'b1;
    wait_bursts("t1_b1", 200);
    push_beats(24);
    expect_burst(32'h1000_0200, 32);
    wait_bursts("t1_b2", 200);

    // 2: partial level waits for frame_end, flush then clears
    push_beats(20);
    idle_window("t2_no_req", 1000);
    expect_burst(32'h1000_0400, 20);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    wait_bursts("t2_flush", 200);
    repeat (3) tick();
    push_beats(20);
    idle_window("t2_flush_cleared", 200);
    expect_burst(32'h1000_0540, 32);
    push_beats(12);
    wait_bursts("t2_full", 200);

    // 3: 4 KB boundary split
    cfg_base = 32'h1000_0F80;
    do_reset();
    expect_burst(32'h1000_0F80, 8);
    expect_burst(32'h1000_1000, 32);
    push_beats(40);
    wait_bursts("t3", 400);

    // 4: frame of two bursts, wrap back to base
    cfg_base        = 32'h2000_0000;
    cfg_frame_bytes = 32'h0000_0400;
    do_reset();
    done_cnt = 0;
    expect_burst(32'h2000_0000, 32);
    expect_burst(32'h2000_0200, 32);
    expect_burst(32'h2000_0000, 32);
    push_beats(96);
    wait_bursts("t4", 600);
    chk("t4_frame_done_cnt", DATA_W'(done_cnt), DATA_W'(1));

    // 5: enable dropped mid-read still completes the burst
    expect_burst(32'h2000_0200, 32);
    push_beats(32);
    n = 0;
    while (fifo_rd_en !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_read_started", DATA_W'(n < 100), DATA_W'(1));
    enable = 1'b0;
    wait_bursts("t5", 200);
    chk("t5_busy", DATA_W'(busy), '0);
    chk("t5_frame_done_cnt", DATA_W'(done_cnt), DATA_W'(2));
    push_beats(32);
    idle_window("t5_no_req", 100);

    // 6: async reset in the middle of a read
    expect_burst(32'h2000_0000, 32);
    enable = 1'b1;
    n = 0;
    req_cycles = 0;
    while (req_cycles < 10 && n < 300) begin
      tick();
      if (fifo_rd_en === 1'b1) req_cycles++;
      n++;
    end
    chk("t6_read_reached", DATA_W'(n < 300), DATA_W'(1));
    rst_n = 1'b0;
    #1 chk_reset_outputs("t6_async");
    cfg_base = 32'h3000_0000;
    repeat (2) tick();
    resync_beats();
    expect_burst(32'h3000_0000, 32);
    push_beats(32);
    rst_n = 1'b1;
    wait_bursts("t6_restart", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_fifo_burst_sched.md
Name: pcie_fifo_burst_sched

Overview:
- Single-clock read-side scheduler for the PCIe staging FIFO. It watches the FIFO read water level and builds DMA write bursts from it.
- For each burst it requests the PCIe DMA engine, drains exactly the granted beat count from the FIFO, and generates burst addresses that wrap inside a host frame buffer.
- It sits between the FIFO read port (FIFO and scheduler share the same rd clock) and the DMA TLP engine.

Parameters:
- DATA_W, 128, FIFO read data width / DMA beat width (bits).
- LVL_W, 11, FIFO read water level width (read depth width + 1).
- BURST_LEN, 32, maximum beats per burst (power of two, ≤ 2^(LVL_W-1)).
- RD_LAT, 1, FIFO rd_en-to-rd_data latency in cycles (1 or 2).
- ADDR_W, 32, host byte address width.

Ports:
- clk  in  1  single clock; also drives FIFO rd_clk.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new bursts to start.
- cfg_base  in  ADDR_W  frame buffer base; 4 KB aligned.
- cfg_frame_bytes  in  ADDR_W  frame size in bytes; multiple of DATA_W/8.
- frame_end  in  1  one-cycle pulse; flush the partial tail.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  DATA_W  FIFO read data.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_level  in  LVL_W  FIFO read water level.
- dma_req  out  1  burst request.
- dma_ack  in  1  one-cycle grant.
- dma_addr  out  ADDR_W  burst byte address; stable while dma_req=1.
- dma_len  out  $clog2(BURST_LEN)+1  burst beats; stable while dma_req=1.
- dma_valid  out  1  beat strobe; the DMA engine accepts every valid beat, with no backpressure.
- dma_data  out  DATA_W  beat data.
- frame_done  out  1  one-cycle pulse when the frame's last byte has been sent.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - Address pointer = 0; it is loaded from cfg_base on the first IDLE cycle with enable=1 and on every frame wrap.
  - flush_pend = 0. FSM = IDLE.
- Derived quantities:
  - BPB = DATA_W/8.
  - rem_frame = (cfg_frame_bytes − frame_off)/BPB.
  - to_4k = (4096 − addr[11:0])/BPB.
  - len = min(BURST_LEN, rem_frame, to_4k, fifo_rd_level).
  - All computed in ADDR_W-bit unsigned arithmetic. Bursts never cross a 4 KB boundary or the frame end.
- flush_pend:
  - Set by frame_end.
  - Cleared on entry to IDLE when fifo_rd_level == 0 and no frame_end arrives that cycle.
  - frame_end in any state sets it; it is never lost.
- IDLE: go to REQ, latching dma_addr/dma_len, when enable=1 and either:
  - fifo_rd_level ≥ min(BURST_LEN, rem_frame, to_4k), or
  - flush_pend=1 and fifo_rd_level > 0.
- REQ:
  - dma_req=1 until a cycle with dma_ack=1 (sampled, then go to READ). dma_ack outside REQ is ignored.
  - enable dropping in REQ does not cancel the request.
- READ:
  - fifo_rd_en=1 for exactly dma_len consecutive cycles; beat counter decrements.
  - fifo_rd_en is never asserted with fifo_rd_empty=1. Level was checked at request time; an empty FIFO here is a protocol error, so hold the read until not empty.
  - Then go to DRAIN.
- Data path:
  - dma_valid/dma_data = fifo_rd_en delayed RD_LAT cycles, through a shift register of valid bits.
  - Data passes through combinationally from fifo_rd_data, aligned by that shift register.
  - Exactly dma_len dma_valid pulses per burst.
- DRAIN:
  - Wait RD_LAT cycles until the last valid beat has gone out.
  - Then update addr += len×BPB and frame_off += len×BPB.
  - If frame_off == cfg_frame_bytes: addr ← cfg_base, frame_off ← 0, pulse frame_done (same cycle as the return to IDLE).
  - Then go to IDLE.
- enable deasserted mid-burst: the current burst completes in full; no new burst starts.
- cfg_* changes are honoured only at frame wrap or on the first enable from reset.
- Back-to-back bursts: minimum gap of 2 cycles (DRAIN→IDLE→REQ).

Decomposition:
- Package pcie_dma_pkg: FSM state enum (IDLE, REQ, READ, DRAIN), BPB function, the 4 KB constant.
- One natural sub-module: pcie_burst_len_calc (combinational min of four terms plus the address/offset adder), reused by a future read-DMA scheduler.

Test Plan:
1. Reset with level=40, enable=1, base=0x1000_0000, frame=0x10_0000:
   - burst 1: dma_addr=0x1000_0000, len=32, 32 dma_valid beats in FIFO order, first beat RD_LAT cycles after the first fifo_rd_en;
   - next burst address 0x1000_0200.
2. Level=20, no frame_end: no dma_req for 1000 cycles. Pulse frame_end: one burst with len=20; flush_pend then clears.
3. base=0x1000_0F80 (BPB=16): first len = 8 (to_4k), next dma_addr=0x1000_1000 with len=32.
4. frame=0x400, level held ≥32: exactly two bursts, frame_done pulses once, third burst dma_addr returns to cfg_base.
5. Deassert enable during READ: the burst still delivers all 32 beats, then busy=0 and no dma_req while enable=0.
6. Assert rst_n=0 mid-READ: all outputs 0 immediately (async); after release no beats leak and the first burst restarts at cfg_base.
